// File: rtl/led_pkg.sv
// Shared definitions for the LED output stage: mode encodings, FSM state
// encoding and the helpers that map between modes and states.
package led_pkg;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_ON      = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_BREATHE = 2'b11;

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_ON      = 3'd1,
    S_BLINK   = 3'd2,
    S_UP      = 3'd3,
    S_HOLD_HI = 3'd4,
    S_DN      = 3'd5,
    S_HOLD_LO = 3'd6
  } state_t;

  // The mode a state belongs to; all four breathe states count as one mode.
  function automatic logic [1:0] state_mode(state_t s);
    case (s)
      S_ON:                               state_mode = MODE_ON;
      S_BLINK:                            state_mode = MODE_BLINK;
      S_UP, S_HOLD_HI, S_DN, S_HOLD_LO:   state_mode = MODE_BREATHE;
      default:                            state_mode = MODE_OFF;
    endcase
  endfunction

  // The state a freshly selected mode starts in.
  function automatic state_t mode_entry(logic [1:0] m);
    case (m)
      MODE_ON:      mode_entry = S_ON;
      MODE_BLINK:   mode_entry = S_BLINK;
      MODE_BREATHE: mode_entry = S_UP;
      default:      mode_entry = S_OFF;
    endcase
  endfunction

endpackage

// File: rtl/led_pwm.sv
// PWM back end: free-running counter, wrap pulse, optional gamma stage and
// the registered duty compare that drives the LED pin.
// Optional feature macro: LED_GAMMA_EN (square-law duty, one extra cycle of latency).
module led_pwm
  import led_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                en_i,
  input  logic                force_on,
  input  logic [PWM_BITS-1:0] duty,
  output logic                led_o,
  output logic                period_o
);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] duty_eff;
  logic                period_q, period_d;
  logic                led_q, led_d;

`ifdef LED_GAMMA_EN
  logic [PWM_BITS-1:0]   duty_eff_q, duty_eff_d;
  logic [2*PWM_BITS-1:0] duty_sq;

  // Square the duty and keep the top half so the ramp looks perceptually even.
  always_comb begin
    duty_sq    = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, duty};
    duty_eff_d = duty_sq[2*PWM_BITS-1:PWM_BITS];
  end

  // Register the corrected duty to keep the multiplier off the compare path.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) duty_eff_q <= '0;
    else          duty_eff_q <= duty_eff_d;
  end

  assign duty_eff = duty_eff_q;
`else
  assign duty_eff = duty;
`endif

  // Counter advance, wrap pulse and LED compare; everything freezes and the LED goes dark when disabled.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q;
    period_d  = 1'b0;
    led_d     = 1'b0;
    if (en_i) begin
      pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
      period_d  = (pwm_cnt_d == '0);
      led_d     = force_on | (duty_eff > pwm_cnt_q);
    end
  end

  // PWM state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pwm_cnt_q <= '0;
      period_q  <= 1'b0;
      led_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      period_q  <= period_d;
      led_q     <= led_d;
    end
  end

  assign led_o    = led_q;
  assign period_o = period_q;

endmodule

// File: rtl/led_breathe.sv
// LED output stage: mode FSM (off/on/blink/breathe) with its step, hold and
// blink counters, feeding the led_pwm back end.
// Optional feature macro: LED_GAMMA_EN (handled inside led_pwm; level_o stays linear).
module led_breathe
  import led_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int STEP_DIV    = 4,
  parameter int HOLD_TICKS  = 64,
  parameter int BLINK_TICKS = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                tick_i,
  input  logic                en_i,
  input  logic [1:0]          mode_i,
  output logic                led_o,
  output logic [PWM_BITS-1:0] level_o,
  output logic                period_o
);

  localparam int STEP_W  = (STEP_DIV    > 1) ? $clog2(STEP_DIV)    : 1;
  localparam int HOLD_W  = (HOLD_TICKS  > 1) ? $clog2(HOLD_TICKS)  : 1;
  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [STEP_W-1:0]   STEP_LAST  = STEP_W'(STEP_DIV - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
  localparam logic [PWM_BITS-1:0] LVL_MAX    = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] LVL_ONE    = PWM_BITS'(1);

  state_t               state_q, state_d;
  logic [PWM_BITS-1:0]  level_q, level_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [BLINK_W-1:0]   blink_q, blink_d;
  logic                 tick_ok;
  logic                 force_on;

  // A tick sharing the cycle with period_o is dropped so mode switching never races a step.
  assign tick_ok  = tick_i & en_i & ~period_o;
  assign force_on = (state_q == S_ON);

  // Next-state logic: a new mode is only taken at the PWM wrap; otherwise the current mode runs.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    step_d  = step_q;
    hold_d  = hold_q;
    blink_d = blink_q;
    if (period_o && (mode_i != state_mode(state_q))) begin
      state_d = mode_entry(mode_i);
      step_d  = '0;
      hold_d  = '0;
      blink_d = '0;
      level_d = (mode_i == MODE_ON) ? LVL_MAX : '0;
    end else begin
      case (state_q)
        S_OFF: level_d = '0;
        S_ON:  level_d = LVL_MAX;
        S_BLINK: begin
          if (tick_ok) begin
            if (blink_q == BLINK_LAST) begin
              blink_d = '0;
              level_d = (level_q == '0) ? LVL_MAX : '0;
            end else begin
              blink_d = blink_q + BLINK_W'(1);
            end
          end
        end
        S_UP: begin
          if (tick_ok) begin
            if (step_q == STEP_LAST) begin
              step_d = '0;
              if (level_q != LVL_MAX) level_d = level_q + LVL_ONE;
              if (level_q >= LVL_MAX - LVL_ONE) begin
                state_d = S_HOLD_HI;
                hold_d  = '0;
              end
            end else begin
              step_d = step_q + STEP_W'(1);
            end
          end
        end
        S_HOLD_HI: begin
          if (tick_ok) begin
            if (hold_q == HOLD_LAST) begin
              state_d = S_DN;
              hold_d  = '0;
              step_d  = '0;
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
        end
        S_DN: begin
          if (tick_ok) begin
            if (step_q == STEP_LAST) begin
              step_d = '0;
              if (level_q != '0) level_d = level_q - LVL_ONE;
              if (level_q <= LVL_ONE) begin
                state_d = S_HOLD_LO;
                hold_d  = '0;
              end
            end else begin
              step_d = step_q + STEP_W'(1);
            end
          end
        end
        S_HOLD_LO: begin
          if (tick_ok) begin
            if (hold_q == HOLD_LAST) begin
              state_d = S_UP;
              hold_d  = '0;
              step_d  = '0;
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
        end
        default: begin
          state_d = S_OFF;
          level_d = '0;
        end
      endcase
    end
  end

  // FSM and counter registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_OFF;
      level_q <= '0;
      step_q  <= '0;
      hold_q  <= '0;
      blink_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      blink_q <= blink_d;
    end
  end

  assign level_o = level_q;

  led_pwm #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .en_i     (en_i),
    .force_on (force_on),
    .duty     (level_q),
    .led_o    (led_o),
    .period_o (period_o)
  );

endmodule

// File: tb/tb_led_breathe.sv
// Directed bench for led_breathe with default parameters; tick every 4 clocks.
module tb_led_breathe;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       en;
  logic [1:0] mode;
  logic       led;
  logic [7:0] level;
  logic       period;

  int vectors     = 0;
  int miscompares = 0;
  int kcnt        = 0;
  int cyc         = 0;
  int r           = 0;
  bit tick_run    = 1'b1;
  bit force_tick  = 1'b0;

  typedef struct {
    int at_cycle;
    int exp_level;
  } vec_t;

  vec_t vecs [16];

`ifdef LED_GAMMA_EN
  localparam int EXP_HIGH_64 = 16;
`else
  localparam int EXP_HIGH_64 = 64;
`endif

  led_breathe dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .tick_i   (tick),
    .en_i     (en),
    .mode_i   (mode),
    .led_o    (led),
    .level_o  (level),
    .period_o (period)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input integer actual, input integer expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Each call: drive inputs for the next edge, take the edge, sample 1 time unit later.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      tick = force_tick || (tick_run && (en ? (kcnt % 4 == 2) : (cyc % 4 == 0)));
      @(posedge clk);
      if (!rst_n) kcnt = 0;
      else if (en) kcnt++;
      cyc++;
      r++;
      #1;
    end
  endtask

  // Run until period_o is seen, checking outputs hold their old-mode values meanwhile.
  task automatic waitPeriod(input string name, input integer exp_led, input integer exp_lvl);
    int found;
    int bad;
    found = 0;
    bad   = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      applyStimulus(1);
      if (led !== exp_led[0] || level !== exp_lvl[7:0]) bad++;
      if (period === 1'b1) found = 1;
    end
    checkOutput({name, "_period_seen"}, found, 1);
    checkOutput({name, "_hold_before_wrap"}, bad, 0);
    r = 0;
  endtask

  initial begin
    int cnt_a;
    int cnt_b;
    int found;

    // level_o after r edges from the breathe entry edge (tick edges at r = 3 mod 4)
    vecs = '{'{1, 0}, '{12, 0}, '{16, 1}, '{23, 1}, '{31, 2}, '{1607, 100},
             '{4078, 254}, '{4079, 255}, '{4200, 255}, '{4350, 255}, '{4351, 254},
             '{5222, 200}, '{8414, 1}, '{8415, 0}, '{8670, 0}, '{8687, 1}};

    rst_n = 1'b0;
    en    = 1'b1;
    mode  = 2'b00;
    tick  = 1'b0;
    applyStimulus(3);
    checkOutput("reset_led", led, 0);
    checkOutput("reset_level", level, 0);
    checkOutput("reset_period", period, 0);

    // Off -> On: nothing changes until the first wrap
    rst_n = 1'b1;
    mode  = 2'b01;
    waitPeriod("off_to_on", 0, 0);
    applyStimulus(1);
    cnt_a = 0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1);
      if (led === 1'b1) cnt_a++;
    end
    checkOutput("on_led_high_cycles", cnt_a, 256);
    checkOutput("on_level", level, 255);

    // On -> Breathe mid-period, with a tick forced onto the entry edge
    mode = 2'b11;
    waitPeriod("on_to_breathe", 1, 255);
    force_tick = 1'b1;
    applyStimulus(1);
    force_tick = 1'b0;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].at_cycle - r);
      checkOutput($sformatf("breathe_level_at_%0d", vecs[i].at_cycle), level, vecs[i].exp_level);
    end

    // Asynchronous reset mid-ramp, then wait for the wrap with mode still breathe
    rst_n = 1'b0;
    kcnt  = 0;
    #1;
    checkOutput("midreset_led", led, 0);
    checkOutput("midreset_level", level, 0);
    checkOutput("midreset_period", period, 0);
    applyStimulus(3);
    rst_n = 1'b1;
    waitPeriod("after_reset", 0, 0);
    applyStimulus(1);
    applyStimulus(22);
    checkOutput("restart_level_at_23", level, 1);

    // Park the ramp at level 64 and count high cycles over one full period
    applyStimulus(1030 - r);
    checkOutput("park_level", level, 64);
    tick_run = 1'b0;
    applyStimulus(2);
    cnt_a = 0;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1);
      if (led === 1'b1) cnt_a++;
    end
    checkOutput("duty64_high_cycles", cnt_a, EXP_HIGH_64);
    checkOutput("park_level_held", level, 64);
    tick_run = 1'b1;

    // Ramp up to the top, then down to 200
    found = 0;
    for (int i = 0; i < 6000 && found == 0; i++) begin
      applyStimulus(1);
      if (level === 8'd255) found = 1;
    end
    checkOutput("reach_top", found, 1);
    found = 0;
    for (int i = 0; i < 6000 && found == 0; i++) begin
      applyStimulus(1);
      if (level === 8'd200) found = 1;
    end
    checkOutput("reach_200_falling", found, 1);

    // Two ticks into the next step, disable for 500 cycles while ticks keep arriving
    applyStimulus(8);
    en    = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 500; i++) begin
      applyStimulus(1);
      if (led !== 1'b0) cnt_a++;
      if (period !== 1'b0) cnt_b++;
    end
    checkOutput("disabled_led_high", cnt_a, 0);
    checkOutput("disabled_period_pulses", cnt_b, 0);
    checkOutput("disabled_level", level, 200);

    // Resume: the step counter kept its two ticks, so two more finish the step
    en = 1'b1;
    applyStimulus(7);
    checkOutput("resume_level_before_step", level, 200);
    applyStimulus(1);
    checkOutput("resume_level_after_step", level, 199);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
